win_sched: RTL and testbench
============================

WIN_SCHED -- requirements
Module: win_sched

Interface
REQ-001 SHALL have parameter DIM_LOG2, default 7, log2 of square image side (128x128 image).
REQ-002 SHALL have parameter PAD_VAL, default 8'd0, value substituted for out-of-image window taps.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ready  input  1  image available; a level sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  frame in progress.
REQ-007 SHALL have port iaddr  output  2*DIM_LOG2  source image read address, row*side+col.
REQ-008 SHALL have port idata  input  8  source pixel; combinational return for the current iaddr.
REQ-009 SHALL have port win_data  output  72  3x3 window; tap k at bits [8k+7:8k], k = 3*(dy+1)+(dx+1), dy/dx in {-1,0,1}.
REQ-010 SHALL have port win_valid  output  1  one-cycle kernel start strobe.
REQ-011 SHALL have port k_done  input  1  kernel result valid strobe.
REQ-012 SHALL have port k_result  input  8  kernel output pixel.
REQ-013 SHALL have port addr  output  2*DIM_LOG2  result write address (center pixel).
REQ-014 SHALL have port data_wr  output  8  result write data.
REQ-015 SHALL have port wen  output  1  result write enable, one cycle per pixel.
REQ-016 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, ISSUE, WAIT, WRITE, DONE.
REQ-018 IDLE -> FETCH when ready=1; center (row,col) set to (0,0); tap index set to 0.
REQ-019 FETCH: one tap per cycle, k = 0..8 ascending; 9 cycles; after k=8 -> ISSUE.
REQ-020 In-image tap: iaddr = (row+dy)*side + (col+dx); idata captured into tap k at end of that cycle.
REQ-021 Out-of-image tap (row+dy or col+dx outside 0..side-1): tap k loaded with PAD_VAL; idata ignored; iaddr = center address.
REQ-022 ISSUE: win_valid=1 for exactly one cycle; win_data stable from ISSUE until leaving WAIT; -> WAIT.
REQ-023 WAIT: hold until k_done=1; k_result captured into data_wr register on that edge; -> WRITE.
REQ-024 k_done outside WAIT (including the ISSUE cycle) SHALL be ignored.
REQ-025 WRITE: wen=1 for one cycle; addr = center address; data_wr = captured result.
REQ-026 WRITE, center not last: col+1; col = side-1 wraps to col 0, row+1; -> FETCH.
REQ-027 WRITE, center = (side-1, side-1): -> DONE.
REQ-028 DONE: done=1 one cycle; -> IDLE; busy=0 from the following cycle.
REQ-029 busy=1 in all states except IDLE, including the DONE cycle.
REQ-030 ready in any state other than IDLE SHALL be ignored; ready held high at DONE restarts the frame from IDLE one cycle later.
REQ-031 Per-pixel latency SHALL be 9 (FETCH) + 1 (ISSUE) + N (WAIT, N>=1 cycles to k_done) + 1 (WRITE) cycles.
REQ-032 Address arithmetic SHALL be unsigned, 2*DIM_LOG2 bits; no out-of-range address SHALL ever be driven on iaddr.
REQ-033 wen, win_valid, done SHALL be registered or decoded from state only; no combinational path from k_done or idata to any output.

Reset
REQ-034 On reset: state IDLE; busy, wen, win_valid, done = 0; iaddr, addr, data_wr = 0; win_data = 0; row, col, tap index = 0.
REQ-035 Reset asserted mid-frame SHALL abort immediately; no further wen; restart requires ready in IDLE.

Verification
REQ-036 Ramp image pixel(r,c) = (r+c) mod 256, kernel returns tap4 after 1 cycle -> 16384 writes, addr 0..16383 in order, data_wr = source pixel, done after last write.
REQ-037 Center (0,0), PAD_VAL=0 -> taps 0,1,2,3,6 = 0; taps 4,5,7,8 = pixels at 0,1,128,129; iaddr never exceeds 16383.
REQ-038 Center (0,127) -> taps 2,5,8 = PAD_VAL; next window center (1,0); addr sequence 127 then 128.
REQ-039 k_done pulsed during ISSUE and then after 5 WAIT cycles -> only the second pulse captured; pixel latency 16 cycles.
REQ-040 Reset asserted at pixel 300 WRITE state -> wen=0, busy=0 next cycle; after release with ready=1, first write at addr 0.
REQ-041 ready held high through DONE -> done pulse, one IDLE cycle with busy=0, new frame starts at (0,0).

Source files
------------

// File: rtl/win_sched_if.sv
// Bus bundle between the 3x3 window scheduler, the source image memory,
// the kernel and the result memory.
// Handshake: the kernel sees win_valid for exactly one cycle per window
// and answers later with a single-cycle k_done strobe carrying k_result;
// there is no back-pressure. wen, win_valid and done are single-cycle
// strobes. ready is a level that is sampled only while the scheduler is idle.
interface win_sched_if #(
  parameter int DIM_LOG2 = 7
);
  logic                  ready;
  logic                  busy;
  logic [2*DIM_LOG2-1:0] iaddr;
  logic [7:0]            idata;
  logic [71:0]           win_data;
  logic                  win_valid;
  logic                  k_done;
  logic [7:0]            k_result;
  logic [2*DIM_LOG2-1:0] addr;
  logic [7:0]            data_wr;
  logic                  wen;
  logic                  done;

  modport master (
    input  ready, idata, k_done, k_result,
    output busy, iaddr, win_data, win_valid, addr, data_wr, wen, done
  );

  modport slave (
    output ready, idata, k_done, k_result,
    input  busy, iaddr, win_data, win_valid, addr, data_wr, wen, done
  );
endinterface

// File: rtl/win_sched.sv
// Raster-order 3x3 window scheduler: gathers each window tap by tap,
// hands it to a kernel, then writes the kernel result at the center address.
module win_sched #(
  parameter int         DIM_LOG2 = 7,
  parameter logic [7:0] PAD_VAL  = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  win_sched_if.master bus,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [DIM_LOG2-1:0] EDGE = '1;

  state_t              state_q, state_d;
  logic [DIM_LOG2-1:0] row_q, col_q;
  logic [DIM_LOG2-1:0] tap_row, tap_col;
  logic [3:0]          tap_q;
  logic [1:0]          ty, tx;
  logic                in_img;
  logic                last_px;
  logic [71:0]         win_q;
  logic [7:0]          res_q;

  // ty/tx are dy+1 and dx+1 for the tap currently being fetched
  always_comb begin
    ty = (tap_q >= 4'd6) ? 2'd2 : ((tap_q >= 4'd3) ? 2'd1 : 2'd0);
    tx = 2'(tap_q - 4'(ty) * 4'd3);
  end

  assign in_img  = !((ty == 2'd0 && row_q == '0) || (ty == 2'd2 && row_q == EDGE) ||
                     (tx == 2'd0 && col_q == '0) || (tx == 2'd2 && col_q == EDGE));
  assign tap_row = row_q + DIM_LOG2'(ty) - DIM_LOG2'(1);
  assign tap_col = col_q + DIM_LOG2'(tx) - DIM_LOG2'(1);
  assign last_px = (row_q == EDGE) && (col_q == EDGE);

  // Padded taps park iaddr on the center so the bus never leaves the image
  assign bus.iaddr     = (state_q == FETCH && in_img) ? {tap_row, tap_col} : {row_q, col_q};
  assign bus.addr      = {row_q, col_q};
  assign bus.data_wr   = res_q;
  assign bus.win_data  = win_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.win_valid = (state_q == ISSUE);
  assign bus.wen       = (state_q == WRITE);
  assign bus.done      = (state_q == DONE);
  assign dbg_state     = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ready) state_d = FETCH;
      FETCH:   if (tap_q == 4'd8) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.k_done) state_d = WRITE;
      WRITE:   state_d = last_px ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      tap_q <= 4'd0;
      win_q <= '0;
      res_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ready) begin
            row_q <= '0;
            col_q <= '0;
            tap_q <= 4'd0;
          end
        end
        FETCH: begin
          for (int k = 0; k < 9; k++) begin
            if (tap_q == 4'(k)) win_q[8*k +: 8] <= in_img ? bus.idata : PAD_VAL;
          end
          tap_q <= (tap_q == 4'd8) ? 4'd0 : tap_q + 4'd1;
        end
        WAIT: begin
          if (bus.k_done) res_q <= bus.k_result;
        end
        WRITE: begin
          tap_q <= 4'd0;
          if (!last_px) begin
            if (col_q == EDGE) begin
              col_q <= '0;
              row_q <= row_q + DIM_LOG2'(1);
            end else begin
              col_q <= col_q + DIM_LOG2'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_win_sched.sv
// Directed bench for win_sched on a 32x32 ramp image with a tap-4 kernel.
module tb_win_sched;

  localparam int         DIM  = 5;
  localparam int         SIDE = 32;
  localparam int         NPIX = 1024;
  localparam int         AW   = 2 * DIM;
  localparam logic [7:0] PAD  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  win_sched_if #(.DIM_LOG2(DIM)) bus ();

  win_sched #(.DIM_LOG2(DIM), .PAD_VAL(PAD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, ctr = 0, wen_cnt = 0, last_wen = 0;
  int kdelay = 1, k_wait = 0, f_k = 0;
  bit spur = 1'b0, in_kernel = 1'b0, done_seen = 1'b0;
  logic [7:0]    kernel_px;
  logic [AW-1:0] exp_q[$];

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r + c) & 255);
  endfunction

  function automatic logic [71:0] exp_win(input int ctr_i);
    logic [71:0] w;
    int r, c, rr, cc;
    w = '0;
    r = ctr_i / SIDE;
    c = ctr_i % SIDE;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr >= 0 && rr < SIDE && cc >= 0 && cc < SIDE) w[8*k +: 8] = pix(rr, cc);
      else                                               w[8*k +: 8] = PAD;
    end
    return w;
  endfunction

  function automatic int exp_iaddr(input int ctr_i, input int k);
    int rr, cc;
    rr = ctr_i / SIDE + k / 3 - 1;
    cc = ctr_i % SIDE + k % 3 - 1;
    if (rr >= 0 && rr < SIDE && cc >= 0 && cc < SIDE) return rr * SIDE + cc;
    return ctr_i;
  endfunction

  // Source image: combinational ramp ROM
  assign bus.idata = pix(int'(bus.iaddr[AW-1:DIM]), int'(bus.iaddr[DIM-1:0]));

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs after the edge, act as kernel, score writes
  task automatic cycle();
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    cyc++;
    if (dbg_state == 3'd1) begin
      check("iaddr", 72'(bus.iaddr), 72'(exp_iaddr(ctr, f_k)));
      f_k++;
    end else begin
      f_k = 0;
    end
    bus.k_done   = 1'b0;
    bus.k_result = 8'hEE;
    if (bus.win_valid) begin
      check("win", bus.win_data, exp_win(ctr));
      check("busy_issue", 72'(bus.busy), 72'd1);
      exp_q.push_back(AW'(ctr));
      ctr++;
      kernel_px = bus.win_data[39:32];
      in_kernel = 1'b1;
      k_wait    = 0;
      if (spur) bus.k_done = 1'b1;
    end else if (in_kernel) begin
      k_wait++;
      if (k_wait == kdelay) begin
        bus.k_done   = 1'b1;
        bus.k_result = kernel_px;
        in_kernel    = 1'b0;
      end
    end
    if (bus.wen) begin
      if (exp_q.size() == 0) begin
        check("wen_unexp", 72'(bus.wen), 72'd0);
      end else begin
        ea = exp_q.pop_front();
        check("addr", 72'(bus.addr), 72'(ea));
        check("data_wr", 72'(bus.data_wr), 72'(pix(int'(ea) / SIDE, int'(ea) % SIDE)));
        if (wen_cnt > 0) check("px_latency", 72'(cyc - last_wen), 72'(11 + kdelay));
      end
      wen_cnt++;
      last_wen = cyc;
    end
    if (bus.done) begin
      check("done_frame_wen", 72'(wen_cnt), 72'(NPIX));
      check("done_after_wen", 72'(cyc - last_wen), 72'd1);
      check("done_q_empty", 72'(exp_q.size()), 72'd0);
      check("busy_done", 72'(bus.busy), 72'd1);
      done_seen = 1'b1;
    end
  endtask

  task automatic new_frame_state(input int kd, input bit sp);
    kdelay    = kd;
    spur      = sp;
    ctr       = 0;
    wen_cnt   = 0;
    done_seen = 1'b0;
    in_kernel = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) cycle();
    check("frame_done_seen", 72'(done_seen), 72'd1);
  endtask

  initial begin
    bus.ready    = 1'b0;
    bus.k_done   = 1'b0;
    bus.k_result = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 72'(bus.busy), 72'd0);
    check("rst_wen", 72'(bus.wen), 72'd0);
    check("rst_win_valid", 72'(bus.win_valid), 72'd0);
    check("rst_done", 72'(bus.done), 72'd0);
    check("rst_iaddr", 72'(bus.iaddr), 72'd0);
    check("rst_addr", 72'(bus.addr), 72'd0);
    check("rst_data_wr", 72'(bus.data_wr), 72'd0);
    check("rst_win_data", bus.win_data, 72'd0);
    check("rst_state", 72'(dbg_state), 72'd0);
    reset = 1'b0;
    cycle();
    check("idle_no_ready", 72'(bus.busy), 72'd0);

    // Frame 1: full ramp, kernel answers one cycle into WAIT
    new_frame_state(1, 1'b0);
    bus.ready = 1'b1;
    cycle();
    bus.ready = 1'b0;
    check("start_busy", 72'(bus.busy), 72'd1);
    wait_done(20000);
    cycle();
    check("idle_after_done", 72'(bus.busy), 72'd0);
    check("done_one_cycle", 72'(bus.done), 72'd0);

    // Frame 2: stray k_done during ISSUE, 5-cycle kernel, reset in WRITE of pixel 300
    new_frame_state(5, 1'b1);
    bus.ready = 1'b1;
    cycle();
    bus.ready = 1'b0;
    for (int i = 0; i < 6000 && wen_cnt < 301; i++) cycle();
    check("reach_px300", 72'(wen_cnt), 72'd301);
    reset = 1'b1;
    #1;
    check("abort_wen", 72'(bus.wen), 72'd0);
    check("abort_busy", 72'(bus.busy), 72'd0);
    new_frame_state(1, 1'b0);
    cycle();
    check("abort_wen_next", 72'(bus.wen), 72'd0);
    check("abort_busy_next", 72'(bus.busy), 72'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("no_restart_wo_ready", 72'(bus.busy), 72'd0);

    // Frame 3: restart after reset, ready held high through DONE
    new_frame_state(1, 1'b0);
    bus.ready = 1'b1;
    wait_done(20000);
    cycle();
    check("hold_idle_busy", 72'(bus.busy), 72'd0);
    check("hold_idle_state", 72'(dbg_state), 72'd0);
    new_frame_state(1, 1'b0);
    cycle();
    bus.ready = 1'b0;
    check("hold_restart_busy", 72'(bus.busy), 72'd1);
    check("hold_restart_state", 72'(dbg_state), 72'd1);
    wait_done(20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
